lzy_tdm_demux4: RTL

Four-channel time-division demultiplexer: the receiving end of the 74HC153-style 4-to-1 mux path. It accepts one sample per enabled clock from a serial TDM stream, steers each sample into the channel slot given by an internal 2-bit select counter, and presents a complete 4-channel frame in parallel with a one-cycle valid pulse. In loopback benches it drives the mux select lines, and it recovers the frame position from a frame-sync strobe.

---
 rtl/lzy_demux_pkg.sv | 15 +
 rtl/lzy_ch_dec24.sv | 26 ++
 rtl/lzy_tdm_demux4.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lzy_demux_pkg.sv
// Shared definitions for the lzy_tdm_demux4 four-channel TDM demultiplexer.
//   CH_NUM        : number of TDM channels (fixed at 4)
//   SEL_W         : width of the channel select / slot counter
//   demux_state_e : frame alignment FSM states (hunting for sync, locked to frame)
package lzy_demux_pkg;

    localparam int unsigned CH_NUM = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [0:0] {
        StHunt,
        StLock
    } demux_state_e;

endpackage

// File: rtl/lzy_ch_dec24.sv
// 2-to-4 one-hot decoder with active-low enable (74HC139-style), producing per-slot
// write enables for the demultiplexer's channel slots. Outputs are active-high.
//   sel_i : slot index to decode
//   en_ni : active-low enable; when 1 all outputs are 0
//   y_o   : one-hot slot enable, y_o[k] = 1 when enabled and sel_i == k
module lzy_ch_dec24
    import lzy_demux_pkg::*;
(
    input  logic [SEL_W-1:0]  sel_i,
    input  logic              en_ni,
    output logic [CH_NUM-1:0] y_o
);

    always_comb begin
        y_o = '0;
        if (!en_ni) begin
            unique case (sel_i)
                2'd0:    y_o = 4'b0001;
                2'd1:    y_o = 4'b0010;
                2'd2:    y_o = 4'b0100;
                default: y_o = 4'b1000;
            endcase
        end
    end

endmodule

// File: rtl/lzy_tdm_demux4.sv
// Four-channel time-division demultiplexer. Accepts one sample per enabled clock,
// steers it into the slot given by a 2-bit counter and presents a complete frame in
// parallel with a one-cycle valid pulse. Frame position is recovered from a sync strobe.
//
// Build option: LZY_DEMUX_SYNC_CHK_EN
//   defined   : sync arriving mid-frame realigns the counter, drops the partial frame
//               and sets the sticky sync_err flag
//   undefined : sync only matters while hunting; the counter free-runs once locked and
//               sync_err is tied to 0
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   en_n      : active-low enable; when 1 all state holds and frame_vld is 0
//   sync      : frame strobe, marks the current din as channel 0
//   din       : serial TDM sample
//   sel_o     : slot the next enabled sample will land in (drives mux S in loopback)
//   q         : frame register, channel k in q[k*W +: W]
//   frame_vld : one-cycle pulse the cycle after a full frame is loaded into q
//   locked    : high while locked to the frame
//   sync_err  : sticky, sync seen mid-frame
module lzy_tdm_demux4
    import lzy_demux_pkg::*;
#(
    parameter int unsigned W  = 1,
    parameter int unsigned CH = CH_NUM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_n,
    input  logic              sync,
    input  logic [W-1:0]      din,
    output logic [SEL_W-1:0]  sel_o,
    output logic [CH*W-1:0]   q,
    output logic              frame_vld,
    output logic              locked,
    output logic              sync_err
);

    demux_state_e      state_q;
    logic [SEL_W-1:0]  cnt_q;
    // Slot 3 goes straight from din into q, so only three slots are buffered.
    logic [W-1:0]      shadow_q [3];
    logic [CH*W-1:0]   q_q;
    logic              frame_vld_q;
    logic [CH_NUM-1:0] slot_we;
    logic              realign;

    lzy_ch_dec24 u_dec (
        .sel_i (cnt_q),
        .en_ni (en_n),
        .y_o   (slot_we)
    );

`ifdef LZY_DEMUX_SYNC_CHK_EN
    logic sync_err_q;

    // Sync while locked and not at slot 0 means the stream slipped.
    assign realign = (state_q == StLock) && sync && (cnt_q != '0) && !en_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_err_q <= 1'b0;
        end else if (realign) begin
            sync_err_q <= 1'b1;
        end
    end

    assign sync_err = sync_err_q;
`else
    assign realign  = 1'b0;
    assign sync_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StHunt;
            cnt_q       <= '0;
            q_q         <= '0;
            frame_vld_q <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            frame_vld_q <= 1'b0;
            if (!en_n) begin
                unique case (state_q)
                    StHunt: begin
                        if (sync) begin
                            shadow_q[0] <= din;
                            cnt_q       <= SEL_W'(1);
                            state_q     <= StLock;
                        end
                    end
                    StLock: begin
                        if (realign) begin
                            // Restart the frame with this sample as channel 0; the
                            // partial frame is discarded and q is left untouched.
                            shadow_q[0] <= din;
                            cnt_q       <= SEL_W'(1);
                        end else begin
                            for (int k = 0; k < 3; k++) begin
                                if (slot_we[k]) begin
                                    shadow_q[k] <= din;
                                end
                            end
                            cnt_q <= cnt_q + SEL_W'(1);
                            if (slot_we[3]) begin
                                q_q         <= {din, shadow_q[2], shadow_q[1], shadow_q[0]};
                                frame_vld_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end
        end
    end

    assign sel_o     = cnt_q;
    assign q         = q_q;
    assign frame_vld = frame_vld_q;
    assign locked    = (state_q == StLock);

endmodule
